// File: rtl/rca_chunk_seq.sv
// rca_chunk_seq: WIDTH-bit add/sub built from one CHUNK-bit ripple-carry adder reused LSB chunk first.
// rca: plain ripple-carry adder used as the per-cycle datapath slice.
module rca #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign sum[g]   = op1[g] ^ op2[g] ^ c[g];
        assign c[g + 1] = (op1[g] & op2[g]) | (c[g] & (op1[g] ^ op2[g]));
    end
    assign cout = c[WIDTH];
endmodule

module rca_chunk_seq #(
    parameter int WIDTH = 256,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             c_out, last;

    assign a_c  = a_q[int'(cnt) * CHUNK +: CHUNK];
    assign b_c  = b_q[int'(cnt) * CHUNK +: CHUNK];
    assign last = cnt == CW'(NCHUNK - 1);

    rca #(.WIDTH(CHUNK)) u_rca (
        .op1 (a_c),
        .op2 (b_c),
        .cin (carry),
        .sum (s_c),
        .cout(c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Subtraction stores ~op2 and seeds the carry with 1, so RUN only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= op1;
            b_q   <= sub ? ~op2 : op2;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum[int'(cnt) * CHUNK +: CHUNK] <= s_c;
            carry <= c_out;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
                cout <= c_out;
                ovf  <= (a_c[CHUNK-1] == b_c[CHUNK-1]) && (s_c[CHUNK-1] != a_c[CHUNK-1]);
            end
        end
    end
endmodule

// File: tb/tb_rca_chunk_seq.sv
// tb_rca_chunk_seq: directed and random checks of the chunked adder/subtractor.
module tb_rca_chunk_seq;
    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] op1, op2, sum;
    int           errors = 0;
    int           checks = 0;

    localparam logic [W-1:0] ALL1 = '1;
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    rca_chunk_seq #(.WIDTH(W), .CHUNK(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issue one request, verify latency and result, then complete the output handshake.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        op1 = a; op2 = b; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op1 = ~a; op2 = ~b; sub = ~s;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(4));
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, W'(cout), W'(ec));
        check({tag, "_ovf"}, W'(ovf), W'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, W'(out_valid), W'(0));
        check({tag, "_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] a, b, bb, hold;
        logic [W:0]   r;
        logic         s, eo;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; op1 = 5; op2 = 7; sub = 1'b0;
        tick();
        tick();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        rst = 1'b0; in_valid = 1'b0;
        repeat (6) tick();
        check("rst_no_accept_valid", W'(out_valid), W'(0));
        check("rst_no_accept_ready", W'(in_ready), W'(1));

        run_op("carry_chain", ALL1, 1, 1'b0, '0, 1'b1, 1'b0);
        run_op("sub_borrow", 5, 7, 1'b1, ALL1 - 1, 1'b0, 1'b0);
        run_op("sub_pos", 7, 5, 1'b1, 2, 1'b1, 1'b0);
        run_op("ovf_add", MSB - 1, 1, 1'b0, MSB, 1'b0, 1'b1);
        run_op("ovf_sub", MSB, 1, 1'b1, MSB - 1, 1'b1, 1'b1);

        // Backpressure: result must hold and no new request may be taken.
        op1 = 100; op2 = 23; sub = 1'b0; in_valid = 1'b1;
        tick();
        op1 = 9; op2 = 9;
        repeat (4) tick();
        check("bp_valid", W'(out_valid), W'(1));
        hold = sum;
        check("bp_sum", hold, 123);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_hold_sum", sum, 123);
            check("bp_hold_cout", W'(cout), W'(0));
            check("bp_hold_ovf", W'(ovf), W'(0));
            check("bp_in_ready", W'(in_ready), W'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", W'(out_valid), W'(0));
        check("bp_release_ready", W'(in_ready), W'(1));
        repeat (6) tick();
        check("bp_no_accept", W'(out_valid), W'(0));

        // Abort in RUN with a pending carry; the next operation must be clean.
        op1 = ALL1; op2 = 1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", W'(out_valid), W'(0));
        check("abort_sum", sum, '0);
        check("abort_ready", W'(in_ready), W'(1));
        run_op("after_abort", 3, 4, 1'b0, 7, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            a = rnd();
            b = rnd();
            s = 1'(($urandom & 1));
            if (k % 50 == 0) a = MSB;
            if (k % 70 == 0) b = ALL1;
            bb = s ? ~b : b;
            r = {1'b0, a} + {1'b0, bb} + (W + 1)'(s);
            eo = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
            run_op("rand", a, b, s, r[W-1:0], r[W], eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
